natv_bus_arbiter: RTL and testbench
===================================

# natv_bus_arbiter

Round-robin arbiter sharing the single native memory bus (valid/addr/wdata/wstrb/rdata/ready) between several bus masters: the CPU core and user master designs. Sits between the masters and the SoC interconnect. Holds one grant per transaction until the slave returns ready. Optionally terminates stalled transactions with a watchdog.

## Interface
- MSTR_NUM, 2: number of requesting masters, legal 2..8; index 0 is the CPU core.
- TIMEOUT_CYC, 1024: watchdog limit in cycles, legal 2..65535; used only with the timeout feature.
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous and active-high
- m_valid_i  in  [MSTR_NUM]  per-master request valid
- m_addr_i  in  [MSTR_NUM][32]  per-master byte address
- m_wdata_i  in  [MSTR_NUM][32]  per-master write data
- m_wstrb_i  in  [MSTR_NUM][4]  per-master byte strobes; 0 means read
- m_rdata_o  out  32  read data, broadcast to all masters
- m_ready_o  out  [MSTR_NUM]  per-master completion, one-hot or zero
- s_valid_o  out  1  slave request valid
- s_addr_o  out  32  slave address
- s_wdata_o  out  32  slave write data
- s_wstrb_o  out  4  slave strobes
- s_rdata_i  in  32  slave read data
- s_ready_i  in  1  slave completion
- gnt_o  out  [MSTR_NUM]  registered one-hot grant, 0 when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort; tied 0 without the feature

## Operation
- The FSM has two states, IDLE and BUSY. An internal round-robin pointer ptr has width clog2(MSTR_NUM).
- IDLE behaviour:
  - If any m_valid_i is set, pick the first set index scanning ptr, ptr+1, … with modulo MSTR_NUM wrap.
  - Register the pick into gnt_o and move to BUSY.
  - If no request is pending, stay in IDLE.
- BUSY behaviour:
  - s_valid_o = m_valid_i[g].
  - s_addr_o, s_wdata_o and s_wstrb_o combinationally mux master g's signals.
  - m_ready_o[g] = s_ready_i.
  - m_rdata_o = s_rdata_i.
- Completion: on s_ready_i && s_valid_o in BUSY:
  - ptr <= (g+1) mod MSTR_NUM.
  - gnt_o <= 0.
  - Next state is IDLE.
- Protocol violation: if the granted master drops valid in BUSY before ready, go to IDLE. ptr is unchanged and no ready is issued.
- Non-granted masters see m_ready_o = 0 and must hold their request until served.
- s_ready_i in IDLE is ignored and is not forwarded.
- Reset mid-operation: IDLE, ptr = 0, gnt_o = 0. All combinational outputs then evaluate to 0.
- Reset values: s_valid_o = 0, s_addr_o = 0, s_wdata_o = 0, s_wstrb_o = 0, m_ready_o = 0, m_rdata_o = 0, gnt_o = 0, timeout_o = 0.
- Outside BUSY, all s_* outputs and m_rdata_o are driven to 0.

## Timing
- Arbitration latency: s_valid_o rises 1 cycle after m_valid_i rises, when the bus is idle.
- Ready path: m_ready_o is combinational from s_ready_i in the same cycle, with zero latency.
- Back-to-back: the cycle after completion is always IDLE, giving 1 bubble. A new grant is visible in the following cycle. Minimum transaction cost is 2 cycles.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,MSTR_NUM-1. No master waits more than MSTR_NUM-1 transactions.
- Simultaneous events: a new m_valid_i arriving in the completion cycle is arbitrated in the next IDLE cycle with the already-updated ptr.

## Configuration
- Macro: NATV_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle without s_ready_i.
  - When the counter reaches TIMEOUT_CYC-1 with no ready, that cycle completes the transaction as an abort:
    - s_valid_o is forced to 0.
    - m_ready_o[g] = 1.
    - m_rdata_o = 32'hDEAD_BEEF.
    - timeout_o pulses high.
    - ptr advances and the next state is IDLE.
  - s_ready_i arriving in that same cycle wins: it is a normal completion with no timeout pulse.
- Undefined: no counter is built and timeout_o is tied 0. A hung slave stalls the bus indefinitely.

## Structure
- The package natv_arb_pkg holds:
  - the state enum {IDLE, BUSY};
  - the TIMEOUT_RDATA constant, 32'hDEAD_BEEF;
  - localparams for address, data and strobe widths.
- One sub-module, natv_rr_pick: combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot gnt and a valid flag.

## Test plan
- Single request, read: master 1 requests addr 0x0300_0010, slave readies after 3 cycles with rdata 0x1234_5678. Required response:
  - s_valid_o rises 1 cycle after the request.
  - m_ready_o = 2'b10 for one cycle, with m_rdata_o = 0x1234_5678.
  - gnt_o returns to 0.
- Contention: both masters request continuously, slave ready is 1 cycle after valid. Required response:
  - Grants alternate 0,1,0,1.
  - Each transaction takes exactly 2 cycles, including the bubble.
  - The write to 0x0200_0000 with wstrb 4'b0011 appears unaltered on s_*.
- Reset mid-BUSY: assert rst_i while master 0 is granted. The next cycle must show gnt_o = 0, s_valid_o = 0, ptr = 0, and no m_ready_o.
- Valid withdrawal: master 1 drops valid in BUSY. Required response:
  - s_valid_o drops in the same cycle.
  - The FSM returns to IDLE with no ready issued.
  - ptr is unchanged, so master 1 wins the next tie.
- Timeout (NATV_ARB_TIMEOUT_EN, TIMEOUT_CYC = 8): the slave never readies. In the 8th BUSY cycle:
  - m_ready_o[g] = 1 with m_rdata_o = 0xDEAD_BEEF.
  - timeout_o pulses for one cycle and s_valid_o = 0.
- Timeout race: s_ready_i arrives exactly in the 8th BUSY cycle. The transaction must complete normally with slave data and timeout_o = 0.

Source files
------------

// File: rtl/natv_arb_pkg.sv
// natv_arb_pkg: shared types and constants for the native-bus round-robin arbiter.
// The optional watchdog is enabled by defining NATV_ARB_TIMEOUT_EN.
package natv_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Read data returned to a master whose transaction was aborted by the watchdog
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/natv_bus_arbiter_if.sv
// natv_bus_arbiter_if: bundles the per-master request side and the single
// slave-side native bus. "slave" is the arbiter's view (it serves the masters);
// "master" is the view of whatever drives requests and models the slave.
interface natv_bus_arbiter_if
    import natv_arb_pkg::*;
#(
    parameter int MSTR_NUM = 2
) ();

    logic [MSTR_NUM-1:0]             m_valid_i;
    logic [MSTR_NUM-1:0][ADDR_W-1:0] m_addr_i;
    logic [MSTR_NUM-1:0][DATA_W-1:0] m_wdata_i;
    logic [MSTR_NUM-1:0][STRB_W-1:0] m_wstrb_i;
    logic [DATA_W-1:0]               m_rdata_o;
    logic [MSTR_NUM-1:0]             m_ready_o;

    logic                            s_valid_o;
    logic [ADDR_W-1:0]               s_addr_o;
    logic [DATA_W-1:0]               s_wdata_o;
    logic [STRB_W-1:0]               s_wstrb_o;
    logic [DATA_W-1:0]               s_rdata_i;
    logic                            s_ready_i;

    modport slave (
        input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_rdata_i, s_ready_i,
        output m_rdata_o, m_ready_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
    );

    modport master (
        output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_rdata_i, s_ready_i,
        input  m_rdata_o, m_ready_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
    );

endinterface

// File: rtl/natv_rr_pick.sv
// natv_rr_pick: combinational round-robin picker. Scans req starting at ptr,
// wrapping modulo N, and returns the first set request as a one-hot grant.
module natv_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_vld
);

    logic [PTR_W:0] w_sum;

    // First requester at or after ptr wins; the extra sum bit handles the wrap
    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            if (!o_vld && i_req[w_sum[PTR_W-1:0]]) begin
                o_gnt[w_sum[PTR_W-1:0]] = 1'b1;
                o_vld                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/natv_bus_arbiter.sv
// natv_bus_arbiter: round-robin arbiter sharing one native memory bus between
// MSTR_NUM masters (index 0 = CPU core). One grant is held per transaction.
// Define NATV_ARB_TIMEOUT_EN to build the watchdog that aborts stalled
// transactions after TIMEOUT_CYC busy cycles.
module natv_bus_arbiter
    import natv_arb_pkg::*;
#(
    parameter int MSTR_NUM    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    natv_bus_arbiter_if.slave     bus,
    output logic [MSTR_NUM-1:0]   gnt_o,
    output logic                  timeout_o
);

    localparam int PTR_W = $clog2(MSTR_NUM);

    if (MSTR_NUM < 2 || MSTR_NUM > 8) begin : g_bad_mstr_num
        $error("natv_bus_arbiter: MSTR_NUM must be 2..8");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("natv_bus_arbiter: TIMEOUT_CYC must be 2..65535");
    end

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [MSTR_NUM-1:0]  r_gnt;
    logic [PTR_W-1:0]     r_gidx;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_adv;

    logic [MSTR_NUM-1:0]  w_pick_gnt;
    logic                 w_pick_vld;
    logic [PTR_W-1:0]     w_pick_idx;

    logic                 w_cur_vld;
    logic                 w_done;
    logic                 w_abort;

    natv_rr_pick #(
        .N     (MSTR_NUM),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req (bus.m_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_vld (w_pick_vld)
    );

    // One-hot pick to index, so the BUSY mux can select directly
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < MSTR_NUM; i++) begin
            if (w_pick_gnt[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    assign w_cur_vld = (r_state == BUSY) && bus.m_valid_i[r_gidx];
    assign w_done    = w_cur_vld && bus.s_ready_i;
    assign w_ptr_adv = (r_gidx == PTR_W'(MSTR_NUM-1)) ? '0 : r_gidx + PTR_W'(1);
    assign gnt_o     = r_gnt;

`ifdef NATV_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Busy-cycle watchdog: held at zero while idle, counts stalled BUSY cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (!bus.s_ready_i) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // A slave ready in the limit cycle takes priority over the abort
    assign w_abort = w_cur_vld && !bus.s_ready_i && (r_cnt == 16'(TIMEOUT_CYC-1));
`else
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: grant when anything requests, release on completion,
    // abort or the granted master withdrawing its request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_pick_vld) w_state_nxt = BUSY;
            BUSY: if (w_done || w_abort || !w_cur_vld) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant and round-robin pointer; ptr only advances on a finished transaction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gnt  <= '0;
            r_gidx <= '0;
            r_ptr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt  <= w_pick_gnt;
                        r_gidx <= w_pick_idx;
                    end
                end
                BUSY: begin
                    if (w_done || w_abort) begin
                        r_gnt <= '0;
                        r_ptr <= w_ptr_adv;
                    end else if (!w_cur_vld) begin
                        r_gnt <= '0;
                    end
                end
                default: r_gnt <= '0;
            endcase
        end
    end

    // Bus mux: everything is zero outside BUSY; the abort overrides the slave
    always_comb begin
        bus.s_valid_o = 1'b0;
        bus.s_addr_o  = '0;
        bus.s_wdata_o = '0;
        bus.s_wstrb_o = '0;
        bus.m_ready_o = '0;
        bus.m_rdata_o = '0;
        timeout_o     = 1'b0;
        if (r_state == BUSY) begin
            bus.s_addr_o  = bus.m_addr_i[r_gidx];
            bus.s_wdata_o = bus.m_wdata_i[r_gidx];
            bus.s_wstrb_o = bus.m_wstrb_i[r_gidx];
            if (w_abort) begin
                bus.m_ready_o[r_gidx] = 1'b1;
                bus.m_rdata_o         = TIMEOUT_RDATA;
                timeout_o             = 1'b1;
            end else begin
                bus.s_valid_o         = w_cur_vld;
                bus.m_ready_o[r_gidx] = w_done;
                bus.m_rdata_o         = bus.s_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_natv_bus_arbiter.sv
// tb_natv_bus_arbiter: directed scenarios for the native-bus arbiter with
// two masters. Watchdog scenarios run when NATV_ARB_TIMEOUT_EN is defined.
module tb_natv_bus_arbiter;
    import natv_arb_pkg::*;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gnt;
    logic         tout;
    int           n_pass = 0;
    int           n_tot  = 0;

    natv_bus_arbiter_if #(.MSTR_NUM(N)) bus ();

    natv_bus_arbiter #(
        .MSTR_NUM    (N),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .gnt_o     (gnt),
        .timeout_o (tout)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; checks happen at the falling edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.m_valid_i = '0;
        bus.m_addr_i  = '0;
        bus.m_wdata_i = '0;
        bus.m_wstrb_i = '0;
        bus.s_rdata_i = 32'h7777_7777;
        bus.s_ready_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_tot++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b exp 00", gnt); else n_pass++;
        n_tot++; if ({bus.s_valid_o, bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o} !== 69'd0)
            $display("FAIL rst_s_bus: got v=%b a=%h d=%h s=%h exp all 0", bus.s_valid_o, bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o); else n_pass++;
        n_tot++; if (bus.m_ready_o !== 2'b00 || bus.m_rdata_o !== 32'h0)
            $display("FAIL rst_m_resp: got rdy=%b rdata=%h exp 00/0", bus.m_ready_o, bus.m_rdata_o); else n_pass++;
        n_tot++; if (tout !== 1'b0) $display("FAIL rst_timeout: got %b exp 0", tout); else n_pass++;
        tick();
        rst           = 1'b0;
        bus.s_ready_i = 1'b0;
        bus.s_rdata_i = '0;
    endtask

    task automatic test_single_read;
        tick();
        bus.m_valid_i   = 2'b10;
        bus.m_addr_i[1] = 32'h0300_0010;
        bus.m_wstrb_i[1] = 4'b0000;
        @(negedge clk);
        n_tot++; if (bus.s_valid_o !== 1'b0) $display("FAIL rd_arb_latency: s_valid got %b exp 0", bus.s_valid_o); else n_pass++;
        tick();
        @(negedge clk);
        n_tot++; if (bus.s_valid_o !== 1'b1 || gnt !== 2'b10)
            $display("FAIL rd_grant: got v=%b gnt=%b exp 1/10", bus.s_valid_o, gnt); else n_pass++;
        n_tot++; if (bus.s_addr_o !== 32'h0300_0010 || bus.s_wstrb_o !== 4'h0)
            $display("FAIL rd_addr: got a=%h s=%h exp 03000010/0", bus.s_addr_o, bus.s_wstrb_o); else n_pass++;
        tick();
        @(negedge clk);
        n_tot++; if (bus.m_ready_o !== 2'b00) $display("FAIL rd_wait: m_ready got %b exp 00", bus.m_ready_o); else n_pass++;
        tick();
        bus.s_ready_i = 1'b1;
        bus.s_rdata_i = 32'h1234_5678;
        @(negedge clk);
        n_tot++; if (bus.m_ready_o !== 2'b10 || bus.m_rdata_o !== 32'h1234_5678)
            $display("FAIL rd_resp: got rdy=%b rdata=%h exp 10/12345678", bus.m_ready_o, bus.m_rdata_o); else n_pass++;
        tick();
        bus.m_valid_i = 2'b00;
        bus.s_ready_i = 1'b0;
        @(negedge clk);
        n_tot++; if (gnt !== 2'b00 || bus.m_ready_o !== 2'b00 || bus.s_valid_o !== 1'b0)
            $display("FAIL rd_release: got gnt=%b rdy=%b v=%b exp 00/00/0", gnt, bus.m_ready_o, bus.s_valid_o); else n_pass++;
    endtask

    task automatic test_contention;
        logic [N-1:0] exp_g;
        tick();
        bus.m_valid_i    = 2'b11;
        bus.m_addr_i[0]  = 32'h0200_0000;
        bus.m_wdata_i[0] = 32'hA5A5_0F0F;
        bus.m_wstrb_i[0] = 4'b0011;
        bus.m_addr_i[1]  = 32'h0400_0004;
        bus.m_wdata_i[1] = 32'h0;
        bus.m_wstrb_i[1] = 4'b0000;
        bus.s_ready_i    = 1'b1;
        bus.s_rdata_i    = 32'h0BAD_CAFE;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            @(negedge clk);
            n_tot++; if (gnt !== exp_g || bus.m_ready_o !== exp_g)
                $display("FAIL cont_gnt[%0d]: got gnt=%b rdy=%b exp %b", t, gnt, bus.m_ready_o, exp_g); else n_pass++;
            if (t == 0) begin
                n_tot++; if (bus.s_addr_o !== 32'h0200_0000 || bus.s_wdata_o !== 32'hA5A5_0F0F || bus.s_wstrb_o !== 4'b0011)
                    $display("FAIL cont_write: got a=%h d=%h s=%b exp 02000000/a5a50f0f/0011", bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o); else n_pass++;
            end
            tick();
            if (t == 3) bus.m_valid_i = 2'b00;
            @(negedge clk);
            n_tot++; if (gnt !== 2'b00 || bus.m_ready_o !== 2'b00 || bus.s_valid_o !== 1'b0 || bus.m_rdata_o !== 32'h0)
                $display("FAIL cont_bubble[%0d]: got gnt=%b rdy=%b v=%b rdata=%h exp idle zeros", t, gnt, bus.m_ready_o, bus.s_valid_o, bus.m_rdata_o); else n_pass++;
        end
        bus.s_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        // master 0 completes once so ptr moves off zero, then is granted again
        tick();
        bus.m_valid_i = 2'b01;
        tick();
        bus.s_ready_i = 1'b1;
        @(negedge clk);
        n_tot++; if (bus.m_ready_o !== 2'b01) $display("FAIL rmb_first: m_ready got %b exp 01", bus.m_ready_o); else n_pass++;
        tick();
        bus.s_ready_i = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_tot++; if (gnt !== 2'b01) $display("FAIL rmb_granted: gnt got %b exp 01", gnt); else n_pass++;
        tick();
        rst           = 1'b0;
        bus.m_valid_i = 2'b11;
        @(negedge clk);
        n_tot++; if (gnt !== 2'b00 || bus.s_valid_o !== 1'b0 || bus.m_ready_o !== 2'b00)
            $display("FAIL rmb_cleared: got gnt=%b v=%b rdy=%b exp 00/0/00", gnt, bus.s_valid_o, bus.m_ready_o); else n_pass++;
        tick();
        @(negedge clk);
        n_tot++; if (gnt !== 2'b01) $display("FAIL rmb_ptr_zero: gnt got %b exp 01", gnt); else n_pass++;
        bus.s_ready_i = 1'b1;
        tick();
        bus.m_valid_i = 2'b00;
        bus.s_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_withdraw;
        // ptr is 1 here
        bus.m_valid_i = 2'b10;
        tick();
        @(negedge clk);
        n_tot++; if (gnt !== 2'b10 || bus.s_valid_o !== 1'b1)
            $display("FAIL wd_grant: got gnt=%b v=%b exp 10/1", gnt, bus.s_valid_o); else n_pass++;
        tick();
        bus.m_valid_i = 2'b00;
        @(negedge clk);
        n_tot++; if (bus.s_valid_o !== 1'b0 || bus.m_ready_o !== 2'b00)
            $display("FAIL wd_drop: got v=%b rdy=%b exp 0/00", bus.s_valid_o, bus.m_ready_o); else n_pass++;
        tick();
        bus.m_valid_i = 2'b11;
        @(negedge clk);
        n_tot++; if (gnt !== 2'b00) $display("FAIL wd_idle: gnt got %b exp 00", gnt); else n_pass++;
        tick();
        @(negedge clk);
        n_tot++; if (gnt !== 2'b10) $display("FAIL wd_ptr_kept: gnt got %b exp 10", gnt); else n_pass++;
        bus.s_ready_i = 1'b1;
        tick();
        bus.m_valid_i = 2'b00;
        bus.s_ready_i = 1'b0;
        tick();
    endtask

`ifdef NATV_ARB_TIMEOUT_EN
    task automatic test_timeout;
        // ptr is 0 here; slave never readies
        bus.s_rdata_i = 32'h5555_AAAA;
        bus.m_valid_i = 2'b01;
        tick();
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            n_tot++; if (tout !== 1'b0 || bus.m_ready_o !== 2'b00 || bus.s_valid_o !== 1'b1)
                $display("FAIL to_wait[%0d]: got to=%b rdy=%b v=%b exp 0/00/1", c, tout, bus.m_ready_o, bus.s_valid_o); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_tot++; if (tout !== 1'b1 || bus.m_ready_o !== 2'b01 || bus.m_rdata_o !== 32'hDEAD_BEEF || bus.s_valid_o !== 1'b0)
            $display("FAIL to_abort: got to=%b rdy=%b rdata=%h v=%b exp 1/01/deadbeef/0", tout, bus.m_ready_o, bus.m_rdata_o, bus.s_valid_o); else n_pass++;
        tick();
        bus.m_valid_i = 2'b00;
        @(negedge clk);
        n_tot++; if (tout !== 1'b0 || gnt !== 2'b00)
            $display("FAIL to_after: got to=%b gnt=%b exp 0/00", tout, gnt); else n_pass++;
    endtask

    task automatic test_timeout_race;
        tick();
        bus.m_valid_i = 2'b10;
        tick();
        for (int c = 1; c < 8; c++) tick();
        bus.s_ready_i = 1'b1;
        bus.s_rdata_i = 32'hCAFE_0001;
        @(negedge clk);
        n_tot++; if (tout !== 1'b0 || bus.m_ready_o !== 2'b10 || bus.m_rdata_o !== 32'hCAFE_0001 || bus.s_valid_o !== 1'b1)
            $display("FAIL to_race: got to=%b rdy=%b rdata=%h v=%b exp 0/10/cafe0001/1", tout, bus.m_ready_o, bus.m_rdata_o, bus.s_valid_o); else n_pass++;
        tick();
        bus.m_valid_i = 2'b00;
        bus.s_ready_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_reset_mid_busy();
        test_withdraw();
`ifdef NATV_ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
